scan_chain_ctrl: RTL and testbench

- Sequencer for one scan chain of CHAIN_LEN mux-scan flops (SE/SI/D/CLK/RN type, serial SI-to-Q linkage).
- Runs one full test pattern per request: serial load of a parallel pattern, functional capture, then serial unload into a parallel response register.
- Sits between a test/BIST host and the chain.
- Drives the chain's SE, SI and active-low RN; samples the chain's last Q (SO).

---
 rtl/scan_chain_ctrl_pkg.sv | 19 +
 rtl/scan_chain_ctrl_shreg.sv | 40 ++++
 rtl/scan_chain_ctrl.sv | 129 ++++++++++++
 tb/tb_scan_chain_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and helpers for the scan chain sequencer.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } state_e;

    // Wide enough to hold the largest terminal count of any phase.
    function automatic int cnt_width(input int chain_len, input int cap_cycles);
        int m;
        m = (chain_len > cap_cycles) ? chain_len : cap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_shreg.sv
// Shift register with parallel load and serial input; shifts toward the MSB.
module scan_ctrl_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic shift_src;
            if (gi == 0) begin : g_lsb
                assign shift_src = ser_i;
            end else begin : g_upper
                assign shift_src = q_q[gi-1];
            end
            assign q_d[gi] = load_i ? load_val_i[gi] : (shift_i ? shift_src : q_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload sequencer for a single mux-scan chain.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int   CHAIN_LEN  = 8,
    parameter int   CAP_CYCLES = 1,
    parameter logic FILL       = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PAT,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 CHAIN_RN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP
);

    localparam int CNT_W = cnt_width(CHAIN_LEN, CAP_CYCLES);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             se_q, se_d;
    logic             si_q, si_d;
    logic             rn_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic                 pat_load;
    logic                 pat_shift;
    logic                 resp_shift;
    logic [CHAIN_LEN-1:0] pat_vec;
    logic                 pat_unused;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (ABORT)                     state_d = ST_IDLE;
                else if (cnt_q == SHIFT_LAST)  state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (ABORT)                     state_d = ST_IDLE;
                else if (cnt_q == CAP_LAST)    state_d = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                if (ABORT)                     state_d = ST_IDLE;
                else if (cnt_q == SHIFT_LAST)  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
    end

    // Outputs are registered from the next state so they are valid for the whole cycle.
    always_comb begin
        se_d   = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
        busy_d = (state_d == ST_LOAD) || (state_d == ST_CAPTURE) || (state_d == ST_UNLOAD);
        done_d = (state_d == ST_DONE);
        si_d   = FILL;
        if (state_d == ST_LOAD) begin
            si_d = (state_q == ST_IDLE) ? PAT[CHAIN_LEN-1] : pat_vec[CHAIN_LEN-1];
        end
    end

    // The MSB goes straight to SI at START, so the register keeps the remainder pre-shifted.
    assign pat_load   = (state_q == ST_IDLE) && (state_d == ST_LOAD);
    assign pat_shift  = (state_q == ST_LOAD);
    assign resp_shift = (state_q == ST_UNLOAD) && !ABORT;
    assign pat_unused = ^pat_vec[CHAIN_LEN-2:0];

    scan_ctrl_shreg #(.W(CHAIN_LEN)) u_pat (
        .clk_i      (CLK),
        .srst_i     (RST),
        .load_i     (pat_load),
        .load_val_i ({PAT[CHAIN_LEN-2:0], FILL}),
        .shift_i    (pat_shift),
        .ser_i      (FILL),
        .q_o        (pat_vec)
    );

    scan_ctrl_shreg #(.W(CHAIN_LEN)) u_resp (
        .clk_i      (CLK),
        .srst_i     (RST),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (resp_shift),
        .ser_i      (SO),
        .q_o        (RESP)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            se_q    <= 1'b0;
            si_q    <= FILL;
            rn_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            se_q    <= se_d;
            si_q    <= si_d;
            rn_q    <= 1'b1;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SE       = se_q;
    assign SI       = si_q;
    assign CHAIN_RN = rn_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: two sequencers (1 and 3 capture cycles) each driving a 4-flop chain with D = ~Q.
module tb_scan_chain_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, abort0, so0, se0, si0, rn0, busy0, done0;
    logic [3:0] pat0, resp0;
    logic       start1, abort1, so1, se1, si1, rn1, busy1, done1;
    logic [3:0] pat1, resp1;
    logic [3:0] chain0 = 4'b0;
    logic [3:0] chain1 = 4'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    scan_chain_ctrl #(.CHAIN_LEN(4), .CAP_CYCLES(1), .FILL(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .START(start0), .ABORT(abort0), .PAT(pat0), .SO(so0),
        .SE(se0), .SI(si0), .CHAIN_RN(rn0), .BUSY(busy0), .DONE(done0), .RESP(resp0)
    );

    scan_chain_ctrl #(.CHAIN_LEN(4), .CAP_CYCLES(3), .FILL(1'b0)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .ABORT(abort1), .PAT(pat1), .SO(so1),
        .SE(se1), .SI(si1), .CHAIN_RN(rn1), .BUSY(busy1), .DONE(done1), .RESP(resp1)
    );

    always @(posedge clk) begin
        if (!rn0)     chain0 <= 4'b0;
        else if (se0) chain0 <= {chain0[2:0], si0};
        else          chain0 <= ~chain0;
        if (!rn1)     chain1 <= 4'b0;
        else if (se1) chain1 <= {chain1[2:0], si1};
        else          chain1 <= ~chain1;
    end
    assign so0 = chain0[3];
    assign so1 = chain1[3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts dut0 and watches 15 cycles; reports first DONE cycle and DONE count.
    task automatic run_dut0(input logic [3:0] p, output int done_at, output int ndone);
        done_at = -1;
        ndone   = 0;
        pat0 = p; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (done0) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            tick();
        end
    endtask

    logic si_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   done_at, ndone;

    initial begin
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; pat0 = 4'b0;
        start1 = 1'b0; abort1 = 1'b0; pat1 = 4'b0;

        // Reset
        tick(); tick();
        check_val("rst_se", se0, 0);
        check_val("rst_si", si0, 0);
        check_val("rst_rn", rn0, 0);
        check_val("rst_resp", resp0, 0);
        check_val("rst_done", done0, 0);
        check_val("rst_busy", busy0, 0);
        rst = 1'b0;
        check_val("rst_rn_hold", rn0, 0);
        tick();
        check_val("rst_rn_rise", rn0, 1);
        tick();
        $display("[TB] txn reset done");

        // Full pattern 1011, one capture cycle
        pat0 = 4'b1011; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check_val($sformatf("p1_se_c%0d", c), se0, (c <= 4 || c >= 6) ? 1 : 0);
            check_val($sformatf("p1_busy_c%0d", c), busy0, 1);
            check_val($sformatf("p1_done_c%0d", c), done0, 0);
            if (c <= 4) check_val($sformatf("p1_si_c%0d", c), si0, si_seq[c-1]);
            tick();
        end
        check_val("p1_done", done0, 1);
        check_val("p1_busy_done", busy0, 0);
        check_val("p1_se_done", se0, 0);
        check_val("p1_resp", resp0, 4'b0100);
        tick();
        check_val("p1_done_pulse", done0, 0);
        check_val("p1_resp_held", resp0, 4'b0100);
        $display("[TB] txn pattern 1011 resp=%b", resp0);

        // START ignored in LOAD and in DONE
        pat0 = 4'b1011; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        done_at = -1; ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done0) begin
                ndone++;
                done_at = c;
            end
            if (c == 2) pat0 = 4'b0000;
            start0 = (c == 2) || done0;
            tick();
        end
        start0 = 1'b0;
        check_val("ign_ndone", ndone, 1);
        check_val("ign_done_at", done_at, 10);
        check_val("ign_resp", resp0, 4'b0100);
        check_val("ign_busy", busy0, 0);
        $display("[TB] txn start-ignore dones=%0d", ndone);

        // ABORT in UNLOAD cycle 2
        pat0 = 4'b1011; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 6; c++) tick();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        check_val("abt_se", se0, 0);
        check_val("abt_busy", busy0, 0);
        check_val("abt_si", si0, 0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done0) ndone++;
            tick();
        end
        check_val("abt_no_done", ndone, 0);
        run_dut0(4'b0001, done_at, ndone);
        check_val("abt_next_done_at", done_at, 10);
        check_val("abt_next_ndone", ndone, 1);
        check_val("abt_next_resp", resp0, 4'b1110);
        $display("[TB] txn abort then pattern 0001 resp=%b", resp0);

        // Three capture cycles on dut1
        pat1 = 4'b0000; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 13; c++) begin
            check_val($sformatf("cap3_se_c%0d", c), se1, (c <= 4 || (c >= 8 && c <= 11)) ? 1 : 0);
            if (c == 8) check_val("cap3_chain", chain1, 4'b1111);
            if (done1 && done_at < 0) done_at = c;
            tick();
        end
        check_val("cap3_done_at", done_at, 12);
        check_val("cap3_resp", resp1, 4'b1111);
        $display("[TB] txn cap3 pattern 0000 resp=%b", resp1);

        // RST in LOAD cycle 3
        pat0 = 4'b1011; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check_val("mrst_se", se0, 0);
        check_val("mrst_si", si0, 0);
        check_val("mrst_rn", rn0, 0);
        check_val("mrst_busy", busy0, 0);
        check_val("mrst_done", done0, 0);
        check_val("mrst_resp", resp0, 0);
        rst = 1'b0;
        tick();
        check_val("mrst_chain", chain0, 0);
        check_val("mrst_rn_back", rn0, 1);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done0) ndone++;
            tick();
        end
        check_val("mrst_no_done", ndone, 0);
        $display("[TB] txn reset mid-load");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
